// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: sequencer states and requester IDs.
package sram_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, and a conflict goes to
// the requester that was not granted most recently.
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  req_id_t    i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  always_comb begin
    // NOTE: default first so every path assigns o_grant and no latch is inferred.
    o_grant = 2'b00;
    if (i_enable) begin
      case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = (i_last_grant == REQ1) ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port synchronous SRAM between two
// requesters. Define SRAM_ARB_INIT_EN to zero the whole SRAM after reset before any grant.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  logic [1:0]        w_grant;
  logic              w_run;
  logic              w_sweep;
  logic [ADDR_W-1:0] w_sweep_addr;
  logic              w_accept;
  req_id_t           w_acc_id;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  req_id_t           r_last_grant;
  logic              r_pend_valid;
  req_id_t           r_pend_id;

`ifdef SRAM_ARB_INIT_EN
  state_t            r_state;
  logic [ADDR_W-1:0] r_sweep_addr;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state      <= INIT;
      r_sweep_addr <= '0;
    end else if (r_state == INIT) begin
      r_sweep_addr <= r_sweep_addr + ADDR_W'(1);
      if (r_sweep_addr == '1) r_state <= RUN;
    end
  end

  // Outputs are forced quiet while reset is held, even before the state register clears.
  assign w_run        = !reset && (r_state == RUN);
  assign w_sweep      = !reset && (r_state == INIT);
  assign w_sweep_addr = r_sweep_addr;
  assign busy         = reset || (r_state == INIT);
`else
  assign w_run        = !reset;
  assign w_sweep      = 1'b0;
  assign w_sweep_addr = '0;
  assign busy         = 1'b0;
`endif

  rr_arbiter2 u_rr_arbiter2 (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .i_enable     (w_run),
    .o_grant      (w_grant)
  );

  assign req0_ready  = w_grant[0];
  assign req1_ready  = w_grant[1];
  assign w_accept    = |w_grant;
  assign w_acc_id    = w_grant[1] ? REQ1 : REQ0;
  assign w_acc_we    = (w_acc_id == REQ1) ? req1_we    : req0_we;
  assign w_acc_addr  = (w_acc_id == REQ1) ? req1_addr  : req0_addr;
  assign w_acc_wdata = (w_acc_id == REQ1) ? req1_wdata : req0_wdata;

  always_comb begin
    mem_ce   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (w_sweep) begin
      mem_ce   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = w_sweep_addr;
    end else if (w_accept) begin
      mem_ce   = 1'b1;
      mem_we   = w_acc_we;
      mem_addr = w_acc_addr;
      mem_din  = w_acc_wdata;
    end
  end

  // One-entry pending slot: the SRAM returns read data exactly one cycle after the accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= REQ1;
      r_pend_valid <= 1'b0;
      r_pend_id    <= REQ0;
    end else begin
      r_pend_valid <= w_accept && !w_acc_we;
      r_pend_id    <= w_acc_id;
      if (w_accept) r_last_grant <= w_acc_id;
    end
  end

  assign rsp0_valid = !reset && r_pend_valid && (r_pend_id == REQ0);
  assign rsp1_valid = !reset && r_pend_valid && (r_pend_id == REQ1);
  assign rsp0_rdata = rsp0_valid ? mem_dout : '0;
  assign rsp1_rdata = rsp1_valid ? mem_dout : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized self-checking bench for sram_arbiter with a behavioural SRAM and a
// memory/response reference model; follows SRAM_ARB_INIT_EN like the design.
`timescale 1ns/1ps
module tb_sram_arbiter;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef SRAM_ARB_INIT_EN
  localparam logic INIT_EN = 1'b1;
`else
  localparam logic INIT_EN = 1'b0;
`endif

  typedef struct packed {
    logic              v;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } cmd_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready, req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid, req1_ready, req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
  logic              mem_ce, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              busy;

  always #5 clk = ~clk;

  sram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .busy       (busy)
  );

  // Single-port synchronous SRAM: write commits at the edge, read data registered.
  logic [DATA_W-1:0] sram [DEPTH];
  logic [DATA_W-1:0] sram_dout;
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_addr] <= mem_din;
      else        sram_dout      <= sram[mem_addr];
    end
  end
  assign mem_dout = sram_dout;

  // Reference model: expected memory image, conflict winner, expected next response.
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic              prefer;
  logic              pend_v;
  logic              pend_id;
  logic [DATA_W-1:0] pend_data;

  int          n_checks;
  int          n_errors;
  int          obs_g;
  logic        last_rsp0_v, last_rsp1_v;
  logic [DATA_W-1:0] last_rsp0_d;
  cmd_t        c0, c1;
  int          g;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    req0_valid = c0.v; req0_we = c0.we; req0_addr = c0.a; req0_wdata = c0.d;
    req1_valid = c1.v; req1_we = c1.we; req1_addr = c1.a; req1_wdata = c1.d;
  endtask

  task automatic new_cmd(output cmd_t c);
    c.v  = ($urandom_range(0, 3) != 0);
    c.we = 1'($urandom_range(0, 1));
    c.a  = ADDR_W'($urandom_range(0, 7));
    c.d  = DATA_W'($urandom);
  endtask

  // One RUN cycle: drive c0/c1, compare every output with the model, advance the model.
  task automatic step(output int gnt);
    cmd_t c;
    drive();
    #4;
    if (c0.v && c1.v) gnt = prefer ? 1 : 0;
    else if (c0.v)    gnt = 0;
    else if (c1.v)    gnt = 1;
    else              gnt = -1;
    obs_g = req0_ready ? 0 : (req1_ready ? 1 : -1);
    check("ready0", req0_ready, gnt == 0);
    check("ready1", req1_ready, gnt == 1);
    check("busy_run", busy, 0);
    check("rsp0_valid", rsp0_valid, pend_v && !pend_id);
    check("rsp1_valid", rsp1_valid, pend_v && pend_id);
    if (pend_v) check(pend_id ? "rsp1_rdata" : "rsp0_rdata", pend_id ? rsp1_rdata : rsp0_rdata, pend_data);
    last_rsp0_v = rsp0_valid; last_rsp1_v = rsp1_valid; last_rsp0_d = rsp0_rdata;
    pend_v = 1'b0;
    if (gnt >= 0) begin
      c = (gnt == 0) ? c0 : c1;
      check("mem_ce", mem_ce, 1);
      check("mem_we", mem_we, c.we);
      check("mem_addr", mem_addr, c.a);
      check("mem_din", mem_din, c.d);
      if (c.we) exp_mem[c.a] = c.d;
      else begin
        pend_v = 1'b1; pend_id = (gnt == 1); pend_data = exp_mem[c.a];
      end
      prefer = (gnt == 0);
    end else begin
      check("idle_ce", mem_ce, 0);
      check("idle_we", mem_we, 0);
      check("idle_addr", mem_addr, 0);
      check("idle_din", mem_din, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b1;
    drive();
    for (int i = 0; i < n; i++) begin
      #4;
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_mem_ce", mem_ce, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_din", mem_din, 0);
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      check("rst_rsp0_rdata", rsp0_rdata, 0);
      check("rst_busy", busy, INIT_EN);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    prefer = 1'b0;
    pend_v = 1'b0;
  endtask

  task automatic sweep(input int upto);
    drive();
    for (int i = 0; i < upto; i++) begin
      #4;
      check("sweep_busy", busy, 1);
      check("sweep_ce", mem_ce, 1);
      check("sweep_we", mem_we, 1);
      check("sweep_addr", mem_addr, i);
      check("sweep_din", mem_din, 0);
      check("sweep_ready0", req0_ready, 0);
      check("sweep_rsp0", rsp0_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    // Known pre-content: 0xFF if the sweep must clear it, otherwise a traceable pattern.
    for (int i = 0; i < DEPTH; i++) begin
      sram[i]    <= INIT_EN ? DATA_W'(8'hFF) : DATA_W'(i ^ 8'h5A);
      exp_mem[i]  = DATA_W'(i ^ 8'h5A);
    end
    c0 = '{v: 1'b1, we: 1'b0, a: '0, d: '0};
    c1 = '0;
    reset = 1'b1;
    drive();
    @(posedge clk); #1;
    reset_cycles(3);

`ifdef SRAM_ARB_INIT_EN
    sweep(100);
    reset_cycles(1);
    sweep(DEPTH);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    step(g);
    check("post_sweep_ready0", obs_g, 0);
    c0.v = 1'b0;
    c1 = '{v: 1'b1, we: 1'b1, a: 8'h30, d: 8'h77};
    step(g);
    check("post_sweep_rdata0", last_rsp0_d, 0);
`else
    c0.v = 1'b0;
    c1 = '{v: 1'b1, we: 1'b0, a: 8'h05, d: '0};
    step(g);
    check("first_cycle_ready1", obs_g, 1);
`endif

    // Contention: both read every cycle, grants must alternate starting with req0.
    c0 = '{v: 1'b1, we: 1'b0, a: 8'h01, d: '0};
    c1 = '{v: 1'b1, we: 1'b0, a: 8'h02, d: '0};
    for (int i = 0; i < 6; i++) begin
      step(g);
      check("contention_grant", obs_g, i % 2);
    end
    c0.v = 1'b0; c1.v = 1'b0;
    step(g);

    // Single requester write then read of the same word.
    c0 = '{v: 1'b1, we: 1'b1, a: 8'h10, d: 8'hA5};
    step(g);
    c0 = '{v: 1'b1, we: 1'b0, a: 8'h10, d: '0};
    step(g);
    c0.v = 1'b0;
    step(g);
    check("single_rsp0_valid", last_rsp0_v, 1);
    check("single_rsp0_rdata", last_rsp0_d, 8'hA5);
    check("single_rsp1_quiet", last_rsp1_v, 0);

    // Back-to-back read-after-write across requesters.
    c1 = '{v: 1'b1, we: 1'b1, a: 8'h20, d: 8'h3C};
    step(g);
    c1.v = 1'b0;
    c0 = '{v: 1'b1, we: 1'b0, a: 8'h20, d: '0};
    step(g);
    c0.v = 1'b0;
    step(g);
    check("raw_rsp0_valid", last_rsp0_v, 1);
    check("raw_rsp0_rdata", last_rsp0_d, 8'h3C);

    // Random traffic; a command is held until accepted.
    new_cmd(c0);
    new_cmd(c1);
    for (int i = 0; i < 400; i++) begin
      step(g);
      if (g == 0 || !c0.v) new_cmd(c0);
      if (g == 1 || !c1.v) new_cmd(c1);
    end
    c0.v = 1'b0; c1.v = 1'b0;
    step(g);

    // Reset in the cycle after a read accept must swallow that response.
    c0 = '{v: 1'b1, we: 1'b0, a: 8'h10, d: '0};
    step(g);
    c0.v = 1'b0;
    reset_cycles(2);
`ifdef SRAM_ARB_INIT_EN
    sweep(DEPTH);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
`endif
    c1 = '{v: 1'b1, we: 1'b0, a: 8'h10, d: '0};
    step(g);
    c1.v = 1'b0;
    step(g);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port synchronous SRAM. It shares one SRAM between two requesters using a valid/ready handshake and routes each read result back to the requester that issued it. An optional post-reset sweep writes zero to every word before the first request is granted. The block sits between the SRAM and its clients (e.g. a DMA engine and a CPU-side port).

## Interface
Parameters:
- DATA_W, 8, data width of SRAM words and requester data
- ADDR_W, 8, SRAM address width; depth = 2**ADDR_W

Ports (N = 0, 1 for each requester):
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- reqN_valid  in  1  requester N has a command
- reqN_ready  out  1  arbiter accepts requester N's command this cycle
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  word address
- reqN_wdata  in  DATA_W  write data
- rspN_valid  out  1  one-cycle pulse: read data for requester N valid
- rspN_rdata  out  DATA_W  read data; meaningful only while rspN_valid = 1
- mem_ce  out  1  SRAM chip enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_din  out  DATA_W  SRAM write data
- mem_dout  in  DATA_W  SRAM read data, registered by the SRAM one cycle after a read
- busy  out  1  init sweep in progress; no grants issued

## Operation
- States: INIT (init sweep) and RUN. Reset enters INIT when SRAM_ARB_INIT_EN is defined, otherwise RUN.
- INIT: the sweep counter runs from 0 to 2**ADDR_W-1, one word per cycle.
  - Each cycle drives mem_ce=1, mem_we=1, mem_addr=counter, mem_din=0.
  - After the last address, go to RUN. busy=1 throughout INIT.
  - reqN_ready=0 and rspN_valid=0 in INIT.
- RUN: at most one grant per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester not granted most recently (last_grant register).
  - last_grant resets to 1, so requester 0 wins the first conflict.
  - last_grant updates only on an accepted command.
- reqN_ready is combinational: (state==RUN) and (grant==N). It is asserted only while reqN_valid=1.
- Accept = reqN_valid & reqN_ready. In the accept cycle:
  - mem_ce=1, mem_we=reqN_we.
  - mem_addr=reqN_addr, mem_din=reqN_wdata.
- No accept: mem_ce=0, mem_we=0, mem_addr=0, mem_din=0.
- Read accepted in cycle T: rspN_valid=1 in cycle T+1, with rspN_rdata=mem_dout. The owner ID is held in a one-entry pending register.
- Writes produce no response.
- Back-to-back accepts are allowed every cycle, including alternating requesters and read-after-write to the same address. The read returns the newly written data because the SRAM commits the write at the T edge.
- A requester must hold its command fields stable while valid=1 and ready=0.

## Timing
- Reset values: reqN_ready=0, rspN_valid=0, rspN_rdata=0, mem_ce=0, mem_we=0, mem_addr=0, mem_din=0. busy=1 if INIT_EN, else 0.
- Read latency: 1 cycle from accept to rspN_valid. Write completes at the accept edge.
- Throughput: 1 command per cycle in aggregate. Under continuous contention each requester gets every other cycle.
- Init sweep length: exactly 2**ADDR_W cycles after reset deasserts; busy falls on the cycle RUN begins.
- Reset mid-sweep restarts the sweep at address 0.
- Reset in the cycle after a read accept suppresses that rspN_valid.

## Configuration
- SRAM_ARB_INIT_EN defined: INIT state and sweep counter are compiled in; memory reads 0 everywhere after the sweep.
- SRAM_ARB_INIT_EN undefined: no counter, no INIT state. The block enters RUN directly from reset, busy is tied to 0, and the first grant is possible in the first cycle after reset.

## Structure
- Package sram_arb_pkg holds:
  - state enum {INIT, RUN}
  - requester ID type (1 bit) and constants REQ0=0, REQ1=1
- Sub-module rr_arbiter2: 2-way round-robin grant logic.
  - Inputs: valid[1:0], last_grant, enable.
  - Output: grant one-hot.
  - Instantiated once.

## Test plan
- INIT_EN, default params: release reset, hold req0_valid=1 -> busy=1 for 256 cycles, mem_addr steps 0..255 with mem_we=1 and mem_din=0, then req0_ready=1 on cycle 257.
- Single requester: write 0xA5 to 0x10, then read 0x10 -> rsp0_valid one cycle after the read accept, rsp0_rdata=0xA5, rsp1_valid stays 0.
- Contention: both valid every cycle, reads of 0x01 (req0) and 0x02 (req1) -> grants alternate 0,1,0,1 and each rsp arrives on the correct port.
- Read-after-write back-to-back: req1 writes 0x3C to 0x20 in cycle T, req0 reads 0x20 in cycle T+1 -> rsp0_rdata=0x3C in T+2.
- Reset at sweep address 100 -> sweep restarts at 0 and busy lasts 256 more cycles.
- Without INIT_EN: req1 read accepted in the first cycle after reset, busy=0 throughout.
